// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int unsigned PC_W    = 64;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned PC_INC  = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    HOLD    = 2'd2,
    DISCARD = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory read channel: level request held until a single rvalid.
interface fetch_if #(
  parameter int unsigned N       = 64,
  parameter int unsigned INSTR_W = 32
);
  logic               imem_req;
  logic [N-1:0]       imem_addr;
  logic               imem_rvalid;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer catching a fetch response that lands during a decode stall.
module fetch_skid_buf
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic         unload_i,
  input  logic         clear_i,
  input  fetch_entry_t data_i,
  output fetch_entry_t data_o,
  output logic         full_o
);

  fetch_entry_t data_q;
  logic         full_q;

  // Clear wins over load so a redirect never leaves wrong-path data behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else begin
      if (clear_i || unload_i) begin
        full_q <= 1'b0;
      end else if (load_i) begin
        full_q <= 1'b1;
      end
      if (load_i && !clear_i) begin
        data_q <= data_i;
      end
    end
  end

  assign data_o = data_q;
  assign full_o = full_q;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC, single-outstanding imem reads, stall skid and branch redirect/flush.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned N        = 64,
  parameter logic [N-1:0] RESET_PC = '0,
  parameter int unsigned INSTR_W  = fetch_pkg::INSTR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               PCSrc_W,
  input  logic [N-1:0]       PCBranch_W,
  input  logic               stall_F,
  fetch_if.master            imem,
  output logic               valid_F,
  output logic [INSTR_W-1:0] instr_F,
  output logic [N-1:0]       pc_F,
  output logic               flush_D,
  output logic               flush_E,
  output logic               flush_M
);

  fetch_state_t       state_q, state_d;
  logic [N-1:0]       pc_q, pc_d;
  logic [N-1:0]       pend_q, pend_d;
  logic               vld_q, vld_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [N-1:0]       pcf_q, pcf_d;

  logic         skid_load, skid_unload, skid_clear, skid_full;
  fetch_entry_t skid_in, skid_out;
  logic         unused_branch_lsb;

  assign skid_in.instr     = imem.imem_rdata;
  assign skid_in.pc        = pc_q;
  assign unused_branch_lsb = ^PCBranch_W[1:0];

  fetch_skid_buf u_skid (
    .clk      (clk),
    .rst_n    (reset),
    .load_i   (skid_load),
    .unload_i (skid_unload),
    .clear_i  (skid_clear),
    .data_i   (skid_in),
    .data_o   (skid_out),
    .full_o   (skid_full)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      pend_q  <= RESET_PC;
      vld_q   <= 1'b0;
      instr_q <= '0;
      pcf_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      vld_q   <= vld_d;
      instr_q <= instr_d;
      pcf_q   <= pcf_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pend_d      = pend_q;
    vld_d       = vld_q;
    instr_d     = instr_q;
    pcf_d       = pcf_q;
    skid_load   = 1'b0;
    skid_unload = 1'b0;
    skid_clear  = 1'b0;

    unique case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        pend_d = pc_q;
        if (imem.imem_rvalid) begin
          pc_d = pc_q + N'(PC_INC);
          if (!stall_F) begin
            vld_d   = 1'b1;
            instr_d = imem.imem_rdata;
            pcf_d   = pc_q;
          end else begin
            skid_load = 1'b1;
            state_d   = HOLD;
          end
        end else if (!stall_F) begin
          vld_d = 1'b0;
        end
      end
      HOLD: begin
        if (!stall_F) begin
          state_d = REQ;
          if (skid_full) begin
            vld_d       = 1'b1;
            instr_d     = skid_out.instr;
            pcf_d       = skid_out.pc;
            skid_unload = 1'b1;
          end
        end
      end
      DISCARD: begin
        vld_d = 1'b0;
        if (imem.imem_rvalid) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase

    // Redirect overrides stall and response; an in-flight request is drained in DISCARD.
    if (PCSrc_W) begin
      pc_d        = {PCBranch_W[N-1:2], 2'b00};
      vld_d       = 1'b0;
      instr_d     = instr_q;
      pcf_d       = pcf_q;
      skid_load   = 1'b0;
      skid_unload = 1'b0;
      skid_clear  = 1'b1;
      unique case (state_q)
        REQ:     state_d = imem.imem_rvalid ? REQ : DISCARD;
        DISCARD: state_d = DISCARD;
        default: state_d = REQ;
      endcase
    end
  end

  assign imem.imem_req  = (state_q == REQ) || (state_q == DISCARD);
  assign imem.imem_addr = (state_q == DISCARD) ? pend_q : pc_q;

  assign valid_F = vld_q;
  assign instr_F = instr_q;
  assign pc_F    = pcf_q;
  assign flush_D = PCSrc_W;
  assign flush_E = PCSrc_W;
  assign flush_M = PCSrc_W;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a latency-programmable instruction memory.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        PCSrc_W;
  logic [63:0] PCBranch_W;
  logic        stall_F;
  logic        valid_F;
  logic [31:0] instr_F;
  logic [63:0] pc_F;
  logic        flush_D, flush_E, flush_M;

  int n_total = 0;
  int n_bad   = 0;
  int lat     = 1;
  int cnt     = 0;

  fetch_if #(.N(64), .INSTR_W(32)) imem_bus ();

  fetch_unit #(.N(64), .RESET_PC(64'h0), .INSTR_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .PCSrc_W    (PCSrc_W),
    .PCBranch_W (PCBranch_W),
    .stall_F    (stall_F),
    .imem       (imem_bus),
    .valid_F    (valid_F),
    .instr_F    (instr_F),
    .pc_F       (pc_F),
    .flush_D    (flush_D),
    .flush_E    (flush_E),
    .flush_M    (flush_M)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got=running exp=finished");
    $fatal(1);
  end

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return 32'hC0DE_0000 ^ a[31:0];
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Memory answers once per request, lat cycles after the request first appears.
  task automatic mem_step();
    if (!reset) begin
      imem_bus.imem_rvalid = 1'b0;
      cnt = 0;
    end else begin
      if (imem_bus.imem_rvalid) begin
        imem_bus.imem_rvalid = 1'b0;
        cnt = 0;
      end
      if (imem_bus.imem_req) begin
        cnt++;
        if (cnt > lat) begin
          imem_bus.imem_rvalid = 1'b1;
          imem_bus.imem_rdata  = mem_word(imem_bus.imem_addr);
        end
      end else begin
        cnt = 0;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    mem_step();
  endtask

  task automatic wait_req(input string tag, input logic [63:0] a);
    int n = 0;
    while (!(imem_bus.imem_req && imem_bus.imem_addr == a) && n < 20) begin
      tick();
      n++;
    end
    check(tag, 64'(imem_bus.imem_req && imem_bus.imem_addr == a), 64'd1);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    tick();
    while (!valid_F && n < 20) begin
      tick();
      n++;
    end
    check(tag, 64'(valid_F), 64'd1);
  endtask

  initial begin
    reset      = 1'b0;
    PCSrc_W    = 1'b0;
    PCBranch_W = '0;
    stall_F    = 1'b0;
    imem_bus.imem_rvalid = 1'b0;
    imem_bus.imem_rdata  = '0;

    tick();
    tick();
    check("rst_req",   64'(imem_bus.imem_req), 64'd0);
    check("rst_valid", 64'(valid_F), 64'd0);
    check("rst_instr", 64'(instr_F), 64'd0);
    check("rst_pcf",   pc_F, 64'd0);

    // Sequential fetch from RESET_PC
    reset = 1'b1;
    #1 check("idle_req", 64'(imem_bus.imem_req), 64'd0);
    tick();
    check("a_req",  64'(imem_bus.imem_req), 64'd1);
    check("a_addr", imem_bus.imem_addr, 64'h0);
    check("a_vld",  64'(valid_F), 64'd0);
    tick();
    check("b_vld",  64'(valid_F), 64'd0);
    tick();
    check("c_vld",   64'(valid_F), 64'd1);
    check("c_pcf",   pc_F, 64'h0);
    check("c_instr", 64'(instr_F), 64'(mem_word(64'h0)));
    check("c_addr",  imem_bus.imem_addr, 64'h4);
    wait_valid("v4");
    check("v4_pcf", pc_F, 64'h4);
    wait_valid("v8");
    check("v8_pcf", pc_F, 64'h8);

    // Decode stall while the 0x10 response returns
    wait_req("req10", 64'h10);
    check("s1_vld", 64'(valid_F), 64'd1);
    check("s1_pcf", pc_F, 64'hC);
    stall_F = 1'b1;
    tick();
    check("s2_vld",  64'(valid_F), 64'd1);
    check("s2_addr", imem_bus.imem_addr, 64'h10);
    tick();
    check("s3_req", 64'(imem_bus.imem_req), 64'd0);
    check("s3_vld", 64'(valid_F), 64'd1);
    check("s3_pcf", pc_F, 64'hC);
    tick();
    check("s4_req", 64'(imem_bus.imem_req), 64'd0);
    check("s4_pcf", pc_F, 64'hC);
    stall_F = 1'b0;
    tick();
    check("s5_vld",   64'(valid_F), 64'd1);
    check("s5_pcf",   pc_F, 64'h10);
    check("s5_instr", 64'(instr_F), 64'(mem_word(64'h10)));
    check("s5_addr",  imem_bus.imem_addr, 64'h14);

    // Redirect with the 0x20 request still outstanding
    lat = 2;
    wait_req("req20", 64'h20);
    PCSrc_W    = 1'b1;
    PCBranch_W = 64'h200;
    #1;
    check("r0_flD", 64'(flush_D), 64'd1);
    check("r0_flE", 64'(flush_E), 64'd1);
    check("r0_flM", 64'(flush_M), 64'd1);
    tick();
    PCSrc_W = 1'b0;
    #1;
    check("r1_flD",  64'(flush_D), 64'd0);
    check("r1_addr", imem_bus.imem_addr, 64'h20);
    check("r1_vld",  64'(valid_F), 64'd0);
    tick();
    check("r2_req",  64'(imem_bus.imem_req), 64'd1);
    check("r2_addr", imem_bus.imem_addr, 64'h20);
    tick();
    check("r3_addr", imem_bus.imem_addr, 64'h200);
    check("r3_vld",  64'(valid_F), 64'd0);
    wait_valid("v200");
    check("v200_pcf",   pc_F, 64'h200);
    check("v200_instr", 64'(instr_F), 64'(mem_word(64'h200)));

    // Redirect coinciding with rvalid and stall
    lat = 0;
    wait_req("req208", 64'h208);
    check("q0_vld", 64'(valid_F), 64'd1);
    check("q0_pcf", pc_F, 64'h204);
    stall_F    = 1'b1;
    PCSrc_W    = 1'b1;
    PCBranch_W = 64'h300;
    tick();
    PCSrc_W = 1'b0;
    check("q1_vld",  64'(valid_F), 64'd0);
    check("q1_pcf",  pc_F, 64'h204);
    check("q1_addr", imem_bus.imem_addr, 64'h300);
    tick();
    check("q2_req", 64'(imem_bus.imem_req), 64'd0);
    check("q2_vld", 64'(valid_F), 64'd0);
    stall_F = 1'b0;
    tick();
    check("q3_vld",   64'(valid_F), 64'd1);
    check("q3_pcf",   pc_F, 64'h300);
    check("q3_instr", 64'(instr_F), 64'(mem_word(64'h300)));

    // Target alignment and PC wrap
    PCSrc_W    = 1'b1;
    PCBranch_W = 64'h103;
    tick();
    check("q4_addr", imem_bus.imem_addr, 64'h100);
    check("q4_vld",  64'(valid_F), 64'd0);
    PCBranch_W = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    PCSrc_W = 1'b0;
    check("q5_addr", imem_bus.imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    lat = 5;
    tick();
    check("q6_vld",  64'(valid_F), 64'd1);
    check("q6_pcf",  pc_F, 64'hFFFF_FFFF_FFFF_FFFC);
    check("q6_addr", imem_bus.imem_addr, 64'h0);
    check("q6_req",  64'(imem_bus.imem_req), 64'd1);

    // Asynchronous reset mid-request
    reset = 1'b0;
    #1;
    check("mr_req",   64'(imem_bus.imem_req), 64'd0);
    check("mr_vld",   64'(valid_F), 64'd0);
    check("mr_pcf",   pc_F, 64'h0);
    check("mr_instr", 64'(instr_F), 64'd0);
    lat = 1;
    tick();
    tick();
    reset = 1'b1;
    #1 check("mr_idle", 64'(imem_bus.imem_req), 64'd0);
    tick();
    check("mr_req1",  64'(imem_bus.imem_req), 64'd1);
    check("mr_addr1", imem_bus.imem_addr, 64'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Fetch stage: holds the PC, issues instruction-memory reads and presents fetched instructions to decode. It consumes PCSrc_W and PCBranch_W from the writeback-stage branch resolver and redirects the PC on a taken branch. It squashes wrong-path work by flushing its own output and driving flush strobes to the D/E/M pipeline registers. Single outstanding memory request, with a one-entry skid buffer to absorb responses that arrive during a decode stall.

Parameters:
N, 64, PC/address width
RESET_PC, 0, PC value loaded on reset
INSTR_W, 32, instruction width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
PCSrc_W  in  1  taken-branch/redirect from writeback
PCBranch_W  in  N  redirect target
stall_F  in  1  decode not accepting; holds fetch output register
imem_req  out  1  read request, level; held until imem_rvalid
imem_addr  out  N  read address; stable while imem_req=1
imem_rvalid  in  1  read data valid; exactly one per request, same cycle or later
imem_rdata  in  INSTR_W  read data
valid_F  out  1  instr_F/pc_F hold a live instruction
instr_F  out  INSTR_W  fetched instruction
pc_F  out  N  address of instr_F
flush_D  out  1  clear D pipeline register (combinational = PCSrc_W)
flush_E  out  1  clear E pipeline register (combinational = PCSrc_W)
flush_M  out  1  clear M pipeline register (combinational = PCSrc_W)

Behaviour:
- Reset (async, reset=0): pc<=RESET_PC; state<=IDLE; valid_F=0, instr_F=0, pc_F=0; skid empty; imem_req=0.
- States: IDLE, REQ, HOLD, DISCARD. pending_addr register holds the address of the outstanding request.
- IDLE: imem_req=0. Go to REQ next cycle (one bubble after reset release).
- REQ: imem_req=1, imem_addr=pc, pending_addr<=pc.
  - rvalid & !stall_F: output reg<={1,rdata,pc}; pc<=pc+4; stay in REQ. The next request is for pc+4, issued the next cycle, so latency is 1 cycle from response to valid_F.
  - rvalid & stall_F: skid<={rdata,pc}; pc<=pc+4; go to HOLD. Output reg is unchanged.
  - !rvalid & !stall_F: valid_F<=0 (bubble).
  - !rvalid & stall_F: output reg held.
- HOLD: imem_req=0. When !stall_F: output reg<={1,skid}; skid emptied; go to REQ.
- DISCARD: imem_req=1, imem_addr=pending_addr (the old request completes). On rvalid: drop the data, go to REQ. valid_F=0 throughout.
- Redirect (PCSrc_W=1) has highest priority over stall and response, in every state:
  - pc<={PCBranch_W[N-1:2],2'b00}; valid_F<=0; skid emptied.
  - flush_D/E/M=1 in the same cycle.
  - Next state:
    - From REQ without rvalid: DISCARD.
    - From REQ with rvalid: data dropped, go to REQ.
    - From HOLD or IDLE: REQ.
    - From DISCARD: stay in DISCARD; the newer target overwrites pc.
- stall_F never blocks a redirect. The flushed output is invalid even while stall_F=1.
- pc+4 wraps modulo 2^N, with no flag.
- instr_F/pc_F keep their last values when valid_F=0. Consumers qualify with valid_F.
- A reset asserted mid-request abandons the request. The memory side is reset by the same signal.

Decomposition:
- Package fetch_pkg:
  - fetch_state_t enum {IDLE,REQ,HOLD,DISCARD}
  - INSTR_W, PC_INC=4
  - fetch_entry_t struct {instr,pc}
- Sub-module fetch_skid_buf: one-entry buffer with load/unload/clear and a full flag, asynchronous active-low reset.

Test Plan:
- Reset release, RESET_PC=0, memory answers the cycle after each request -> addresses 0,4,8,... in order; valid_F rises 1 cycle after the first rvalid; pc_F=0,4,8.
- stall_F=1 for 3 cycles while the response for 0x10 returns -> state HOLD, imem_req=0, valid_F/pc_F unchanged. After the stall drops, pc_F=0x10 next cycle, then request 0x14.
- PCSrc_W=1, PCBranch_W=0x200, with a request for 0x20 pending and rvalid 2 cycles later -> flush_D/E/M=1 that cycle; imem_addr stays 0x20 until rvalid; data dropped; next request 0x200; first valid pc_F=0x200.
- Redirect in the same cycle as rvalid and stall_F=1 -> data dropped, skid empty, valid_F=0, next request = target.
- PCBranch_W=0x103 -> next imem_addr=0x100. With N=64 and pc=0xFFFF_FFFF_FFFF_FFFC, next address wraps to 0.
- reset asserted while imem_req=1 mid-request -> all outputs return to reset values asynchronously; after release, one IDLE cycle, then request RESET_PC.
